// File: rtl/prga_decrypt_fsm.sv
// RC4 pseudo-random generation loop: walks i/j over the shuffled S array, swaps,
// and XORs each keystream byte with the encrypted ROM byte into the plaintext RAM.
module prga_decrypt_fsm #(
    parameter int unsigned MSG_LENGTH  = 32,
    parameter bit          CHECK_ASCII = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_data_in,
    input  logic [7:0] rom_data_in,
    output logic [7:0] s_address_out,
    output logic [7:0] s_data_out,
    output logic       s_write_enable,
    output logic [7:0] rom_address,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data_out,
    output logic       ram_write_enable,
    output logic       busy,
    output logic       decrypt_finished,
    output logic       key_invalid
);

    typedef enum logic [4:0] {
        StIdle, StSetupSi, StWaitSi, StReadSi, StAssignJ, StSetupSj, StWaitSj, StReadSj,
        StSetupWrSi, StWriteSi, StSetupWrSj, StWriteSj, StSetupF, StWaitF, StReadF,
        StWriteRam, StNextK, StFinish, StFail
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d, s_i_q, s_i_d, s_j_q, s_j_d;
    logic [8:0] k_q, k_d;
    logic       invalid_q, invalid_d;
    logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
    logic [7:0] rom_address_q, rom_address_d, ram_address_q, ram_address_d;
    logic [7:0] ram_data_q, ram_data_d;
    logic       s_we_q, s_we_d, ram_we_q, ram_we_d;

    logic [7:0] plain;
    logic       plain_ok;

    assign plain    = s_data_in ^ rom_data_in;
    assign plain_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            i_q           <= 8'h00;
            j_q           <= 8'h00;
            k_q           <= 9'h000;
            s_i_q         <= 8'h00;
            s_j_q         <= 8'h00;
            invalid_q     <= 1'b0;
            s_address_q   <= 8'h00;
            s_data_q      <= 8'h00;
            rom_address_q <= 8'h00;
            ram_address_q <= 8'h00;
            ram_data_q    <= 8'h00;
            s_we_q        <= 1'b0;
            ram_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            s_i_q         <= s_i_d;
            s_j_q         <= s_j_d;
            invalid_q     <= invalid_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            rom_address_q <= rom_address_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            s_we_q        <= s_we_d;
            ram_we_q      <= ram_we_d;
        end
    end

    // Write strobes are registered from the WRITE_* states, so each lands one cycle
    // after its address/data registers settle.
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        s_i_d         = s_i_q;
        s_j_d         = s_j_q;
        invalid_d     = invalid_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        rom_address_d = rom_address_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        s_we_d        = 1'b0;
        ram_we_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    i_d       = 8'h01;
                    j_d       = 8'h00;
                    k_d       = 9'h000;
                    invalid_d = 1'b0;
                    state_d   = StSetupSi;
                end
            end
            StSetupSi: begin
                s_address_d = i_q;
                state_d     = StWaitSi;
            end
            StWaitSi: state_d = StReadSi;
            StReadSi: begin
                s_i_d   = s_data_in;
                state_d = StAssignJ;
            end
            StAssignJ: begin
                j_d     = j_q + s_i_q;
                state_d = StSetupSj;
            end
            StSetupSj: begin
                s_address_d = j_q;
                state_d     = StWaitSj;
            end
            StWaitSj: state_d = StReadSj;
            StReadSj: begin
                s_j_d   = s_data_in;
                state_d = StSetupWrSi;
            end
            StSetupWrSi: begin
                s_address_d = i_q;
                s_data_d    = s_j_q;
                state_d     = StWriteSi;
            end
            StWriteSi: begin
                s_we_d  = 1'b1;
                state_d = StSetupWrSj;
            end
            StSetupWrSj: begin
                s_address_d = j_q;
                s_data_d    = s_i_q;
                state_d     = StWriteSj;
            end
            StWriteSj: begin
                s_we_d  = 1'b1;
                state_d = StSetupF;
            end
            StSetupF: begin
                // Pre-swap s_i + s_j equals the post-swap sum, so no re-read is needed.
                s_address_d   = s_i_q + s_j_q;
                rom_address_d = k_q[7:0];
                state_d       = StWaitF;
            end
            StWaitF: state_d = StReadF;
            StReadF: begin
                ram_data_d    = plain;
                ram_address_d = k_q[7:0];
                if (!plain_ok) invalid_d = 1'b1;
                state_d = StWriteRam;
            end
            StWriteRam: begin
                ram_we_d = 1'b1;
                state_d  = StNextK;
            end
            StNextK: begin
                if (CHECK_ASCII && invalid_q) begin
                    state_d = StFail;
                end else if (k_q == 9'(MSG_LENGTH - 1)) begin
                    state_d = StFinish;
                end else begin
                    k_d     = k_q + 9'd1;
                    i_d     = i_q + 8'd1;
                    state_d = StSetupSi;
                end
            end
            StFinish: state_d = StFinish;
            StFail:   state_d = StFail;
            default:  state_d = StIdle;
        endcase
    end

    assign s_address_out    = s_address_q;
    assign s_data_out       = s_data_q;
    assign s_write_enable   = s_we_q;
    assign rom_address      = rom_address_q;
    assign ram_address      = ram_address_q;
    assign ram_data_out     = ram_data_q;
    assign ram_write_enable = ram_we_q;
    assign busy             = !((state_q == StIdle) || (state_q == StFinish) ||
                                (state_q == StFail));
    assign decrypt_finished = (state_q == StFinish);
    assign key_invalid      = (state_q == StFail);

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Directed bench: a 3-byte instance with the ASCII check and a 256-byte instance
// without it, each wired to 2-cycle-latency S/ROM/RAM models.
module tb_prga_decrypt_fsm;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic reset = 1'b1;
    logic clr   = 1'b0;
    int   cyc   = 0;
    int   t0    = 0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    logic       a_start = 1'b0, b_start = 1'b0;
    logic [7:0] a_s_rd, a_rom_rd, b_s_rd, b_rom_rd;
    logic [7:0] a_s_addr, a_s_wd, a_rom_addr, a_ram_addr, a_ram_wd;
    logic [7:0] b_s_addr, b_s_wd, b_rom_addr, b_ram_addr, b_ram_wd;
    logic       a_s_we, a_ram_we, a_busy, a_fin, a_inv;
    logic       b_s_we, b_ram_we, b_busy, b_fin, b_inv;

    logic [7:0] s_a [256];
    logic [7:0] ram_a [256];
    logic [7:0] rom_a [256];
    logic [7:0] s_b [256];
    logic [7:0] ram_b [256];
    logic [7:0] rom_b [256];

    int         a_sw_n = 0, a_rw_n = 0, b_sw_n = 0, b_rw_n = 0;
    int         a_sw_t [16];
    int         a_rw_t [16];
    logic [7:0] a_sw_addr [16];
    logic [7:0] a_sw_data [16];
    logic [7:0] b_sw_addr [512];

    logic [7:0] exp_ram [256];
    logic [7:0] exp_s [256];
    logic [7:0] exp_i [256];
    logic [7:0] exp_j [256];

    prga_decrypt_fsm #(.MSG_LENGTH(3), .CHECK_ASCII(1'b1)) u_a (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .start           (a_start),
        .s_data_in       (a_s_rd),
        .rom_data_in     (a_rom_rd),
        .s_address_out   (a_s_addr),
        .s_data_out      (a_s_wd),
        .s_write_enable  (a_s_we),
        .rom_address     (a_rom_addr),
        .ram_address     (a_ram_addr),
        .ram_data_out    (a_ram_wd),
        .ram_write_enable(a_ram_we),
        .busy            (a_busy),
        .decrypt_finished(a_fin),
        .key_invalid     (a_inv)
    );

    prga_decrypt_fsm #(.MSG_LENGTH(256), .CHECK_ASCII(1'b0)) u_b (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .start           (b_start),
        .s_data_in       (b_s_rd),
        .rom_data_in     (b_rom_rd),
        .s_address_out   (b_s_addr),
        .s_data_out      (b_s_wd),
        .s_write_enable  (b_s_we),
        .rom_address     (b_rom_addr),
        .ram_address     (b_ram_addr),
        .ram_data_out    (b_ram_wd),
        .ram_write_enable(b_ram_we),
        .busy            (b_busy),
        .decrypt_finished(b_fin),
        .key_invalid     (b_inv)
    );

    // Registered-address memories: data appears after the edge following the address.
    always @(posedge CLOCK_50) begin
        cyc      <= cyc + 1;
        a_s_rd   <= s_a[a_s_addr];
        a_rom_rd <= rom_a[a_rom_addr];
        b_s_rd   <= s_b[b_s_addr];
        b_rom_rd <= rom_b[b_rom_addr];
        if (clr) begin
            for (int n = 0; n < 256; n++) begin
                s_a[n]   <= 8'(n);
                s_b[n]   <= 8'(n);
                ram_a[n] <= 8'h00;
                ram_b[n] <= 8'h00;
            end
        end else begin
            if (a_s_we)   s_a[a_s_addr]     <= a_s_wd;
            if (a_ram_we) ram_a[a_ram_addr] <= a_ram_wd;
            if (b_s_we)   s_b[b_s_addr]     <= b_s_wd;
            if (b_ram_we) ram_b[b_ram_addr] <= b_ram_wd;
        end
    end

    always @(negedge CLOCK_50) begin
        if (clr) begin
            a_sw_n <= 0;
            a_rw_n <= 0;
            b_sw_n <= 0;
            b_rw_n <= 0;
        end else begin
            if (a_s_we) begin
                if (a_sw_n < 16) begin
                    a_sw_t[a_sw_n[3:0]]    <= cyc - t0;
                    a_sw_addr[a_sw_n[3:0]] <= a_s_addr;
                    a_sw_data[a_sw_n[3:0]] <= a_s_wd;
                end
                a_sw_n <= a_sw_n + 1;
            end
            if (a_ram_we) begin
                if (a_rw_n < 16) a_rw_t[a_rw_n[3:0]] <= cyc - t0;
                a_rw_n <= a_rw_n + 1;
            end
            if (b_s_we) begin
                if (b_sw_n < 512) b_sw_addr[b_sw_n[8:0]] <= b_s_addr;
                b_sw_n <= b_sw_n + 1;
            end
            if (b_ram_we) b_rw_n <= b_rw_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk(tag, 64'({a_s_addr, a_s_wd, a_s_we, a_rom_addr, a_ram_addr, a_ram_wd, a_ram_we,
                      a_busy, a_fin, a_inv}), 64'h0);
    endtask

    // Reset pulse, reload memories, then start; returns 1 time unit after edge 0.
    task automatic launch_a(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        rom_a[0] = r0;
        rom_a[1] = r1;
        rom_a[2] = r2;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        a_start = 1'b1;
        step(1);
        t0 = cyc;
        a_start = 1'b0;
    endtask

    initial begin
        logic [7:0] ms [256];
        logic [7:0] mi, mj, tmp;
        for (int n = 0; n < 256; n++) begin
            rom_a[n] = 8'h00;
            rom_b[n] = 8'(n * 7 + 3);
        end
        rom_b[0] = 8'h00;

        #1 reset = 1'b0;
        #1;
        chk_idle_a("reset_a");
        chk("reset_b", 64'({b_s_addr, b_s_wd, b_s_we, b_rom_addr, b_ram_addr, b_ram_wd,
                            b_ram_we, b_busy, b_fin, b_inv}), 64'h0);
        reset = 1'b1;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        step(10);
        chk_idle_a("idle_no_start");
        chk("idle_no_swr", 64'(a_sw_n), 64'd0);

        // "abc" with a start pulse mid-run that must be ignored
        launch_a(8'h63, 8'h67, 8'h64);
        chk("busy_e0", 64'(a_busy), 64'd1);
        step(4);
        a_start = 1'b1;
        step(1);
        a_start = 1'b0;
        step(7);
        chk("faddr_b0", 64'(a_s_addr), 64'd2);
        step(16);
        chk("faddr_b1", 64'(a_s_addr), 64'd5);
        chk("romaddr_b1", 64'(a_rom_addr), 64'd1);
        step(19);
        chk("fin_e47", 64'({a_fin, a_busy}), 64'b01);
        step(1);
        chk("fin_e48", 64'({a_fin, a_busy, a_inv}), 64'b100);
        chk("ram0", 64'(ram_a[0]), 64'h61);
        chk("ram1", 64'(ram_a[1]), 64'h62);
        chk("ram2", 64'(ram_a[2]), 64'h63);
        chk("ramaddr_last", 64'(a_ram_addr), 64'd2);
        chk("s2", 64'(s_a[2]), 64'd3);
        chk("s3", 64'(s_a[3]), 64'd5);
        chk("s5", 64'(s_a[5]), 64'd2);
        chk("swr_count", 64'(a_sw_n), 64'd6);
        chk("swr_t", 64'({a_sw_t[0][7:0], a_sw_t[1][7:0], a_sw_t[2][7:0], a_sw_t[3][7:0],
                          a_sw_t[4][7:0], a_sw_t[5][7:0]}), 64'h090B191B292B);
        chk("swr_ij", 64'({a_sw_addr[0], a_sw_data[0], a_sw_addr[1], a_sw_data[1]}),
            64'h01010101);
        chk("rwr_count", 64'(a_rw_n), 64'd3);
        chk("rwr_t", 64'({a_rw_t[0][7:0], a_rw_t[1][7:0], a_rw_t[2][7:0]}), 64'h0F1F2F);
        a_start = 1'b1;
        step(20);
        a_start = 1'b0;
        chk("fin_sticky", 64'({a_fin, a_busy, a_inv}), 64'b100);
        chk("fin_no_writes", 64'({a_sw_n[7:0], a_rw_n[7:0]}), 64'h0603);

        // invalid first byte (0x02): written, then FAIL at edge 16
        launch_a(8'h00, 8'h67, 8'h64);
        step(15);
        chk("inv_e15", 64'({a_inv, a_busy}), 64'b01);
        step(1);
        chk("inv_e16", 64'({a_inv, a_busy, a_fin}), 64'b100);
        step(40);
        chk("inv_sticky", 64'(a_inv), 64'd1);
        chk("inv_ram0", 64'(ram_a[0]), 64'h02);
        chk("inv_writes", 64'({a_sw_n[7:0], a_rw_n[7:0]}), 64'h0201);

        // range edges that are legal: space, 'z', 'a'
        launch_a(8'h22, 8'h7F, 8'h66);
        step(48);
        chk("edge_ok_fin", 64'({a_fin, a_inv}), 64'b10);
        chk("edge_ok_ram", 64'({ram_a[0], ram_a[1], ram_a[2]}), 64'h207A61);

        // 0x7B on byte 1
        launch_a(8'h63, 8'h7E, 8'h64);
        step(31);
        chk("x7b_e31", 64'(a_inv), 64'd0);
        step(1);
        chk("x7b_e32", 64'({a_inv, a_fin}), 64'b10);
        chk("x7b_ram1", 64'(ram_a[1]), 64'h7B);

        // 0x60 on byte 0
        launch_a(8'h62, 8'h67, 8'h64);
        step(16);
        chk("x60_e16", 64'(a_inv), 64'd1);

        // 0x21 on the last byte: FAIL takes priority over FINISH
        launch_a(8'h63, 8'h67, 8'h26);
        step(47);
        chk("x21_e47", 64'({a_inv, a_fin}), 64'b00);
        step(1);
        chk("x21_e48", 64'({a_inv, a_fin}), 64'b10);

        // asynchronous reset mid-byte, then a clean rerun
        launch_a(8'h63, 8'h67, 8'h64);
        step(20);
        reset = 1'b0;
        #1;
        chk_idle_a("reset_mid");
        reset = 1'b1;
        launch_a(8'h63, 8'h67, 8'h64);
        step(48);
        chk("rerun_fin", 64'({a_fin, a_inv}), 64'b10);
        chk("rerun_ram", 64'({ram_a[0], ram_a[1], ram_a[2]}), 64'h616263);

        // 256-byte run with wraparound, checked against a reference model
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
        mi = 8'h00;
        mj = 8'h00;
        for (int k = 0; k < 256; k++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            exp_i[k] = mi;
            exp_j[k] = mj;
            tmp = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = tmp;
            exp_ram[k] = ms[8'(ms[mi] + ms[mj])] ^ rom_b[k];
        end
        for (int n = 0; n < 256; n++) exp_s[n] = ms[n];

        reset = 1'b0;
        #1;
        reset = 1'b1;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        b_start = 1'b1;
        step(1);
        t0 = cyc;
        b_start = 1'b0;
        step(4095);
        chk("b_e4095", 64'({b_fin, b_busy}), 64'b01);
        step(1);
        chk("b_e4096", 64'({b_fin, b_busy, b_inv}), 64'b100);
        chk("b_counts", 64'({b_sw_n[15:0], b_rw_n[15:0]}), 64'h02000100);
        chk("b_i_wrap", 64'(b_sw_addr[510]), 64'h00);
        for (int k = 0; k < 256; k++) begin
            chk($sformatf("b_ram[%0d]", k), 64'(ram_b[k]), 64'(exp_ram[k]));
            chk($sformatf("b_s[%0d]", k), 64'(s_b[k]), 64'(exp_s[k]));
            chk($sformatf("b_wi[%0d]", k), 64'(b_sw_addr[2 * k]), 64'(exp_i[k]));
            chk($sformatf("b_wj[%0d]", k), 64'(b_sw_addr[2 * k + 1]), 64'(exp_j[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
